// File: rtl/modarith_pkg.sv
// modarith_pkg: shared op/state encodings and latency constants.
// EXP states exist only when MODARITH_EXP_EN is defined.
package modarith_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_RED = 3'b010,
        OP_MUL = 3'b011,
        OP_EXP = 3'b100
    } op_t;

`ifdef MODARITH_EXP_EN
    typedef enum logic [2:0] {
        S_IDLE, S_ARITH, S_RED, S_MUL,
        S_EXP_MUL, S_EXP_SQ, S_FIN
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_ARITH, S_RED, S_MUL, S_FIN
    } state_t;
`endif

    function automatic int lat_arith();
        return 1;
    endfunction

    function automatic int lat_mul(input int w);
        return w + 1;
    endfunction

    function automatic int lat_red(input int w);
        return 2 * w + 1;
    endfunction

    function automatic int lat_exp(input int w);
        return 2 * w * (w + 1) + 2;
    endfunction

endpackage

// File: rtl/modarith_engine_modmul.sv
// modmul_serial: bit-serial interleaved x*y mod m, MSB of x first.
// Loads on start, then one bit per cycle; done pulses after W bits.
module modmul_serial #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] x,
    input  logic [DATA_WIDTH-1:0] y,
    input  logic [DATA_WIDTH-1:0] m,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] p
);
    localparam int W  = DATA_WIDTH;
    localparam int IW = $clog2(W);

    logic [W-1:0]  x_q, y_q, m_q, acc_q, acc_nx;
    logic [IW-1:0] cnt_q;
    logic [W:0]    mx, dbl, sum;

    // one interleaved step: acc = 2*acc mod m, then + y mod m
    always_comb begin
        mx  = {1'b0, m_q};
        dbl = {acc_q, 1'b0};
        if (dbl >= mx) dbl = dbl - mx;
        sum = dbl + (x_q[W-1] ? {1'b0, y_q} : '0);
        if (sum >= mx) sum = sum - mx;
        acc_nx = sum[W-1:0];
    end

    // operand load and per-bit iteration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '0;
            y_q   <= '0;
            m_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                x_q   <= x;
                y_q   <= y;
                m_q   <= m;
                acc_q <= '0;
                cnt_q <= IW'(W - 1);
                busy  <= 1'b1;
            end else if (busy) begin
                acc_q <= acc_nx;
                x_q   <= {x_q[W-2:0], 1'b0};
                if (cnt_q == '0) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - IW'(1);
                end
            end
        end
    end

    assign p = acc_q;

endmodule

// File: rtl/modarith_engine.sv
// modarith_engine: iterative modular add/sub/reduce/mul/exp engine.
// Exponentiation is built only when MODARITH_EXP_EN is defined.
module modarith_engine
    import modarith_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] modulant,
    output logic                  ready,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  error
);
    localparam int W   = DATA_WIDTH;
    localparam int CW  = $clog2(lat_red(W));
    localparam int RED_LAST = lat_red(W) - 1;

    state_t         state_q, go_state;
    logic [2:0]     op_q;
    logic [W-1:0]   a_q, b_q, m_q;
    logic           err_q, accept, bad_op;
    logic [2*W-1:0] div_q;
    logic [W:0]     rem_q, mx, sum_ab;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   add_r, sub_r, red_r, arith_r;
    logic           mul_start, mul_busy, mul_done;
    logic [W-1:0]   mul_x, mul_y, mul_m, mul_p;

`ifdef MODARITH_EXP_EN
    localparam int IW = $clog2(W);
    logic [W-1:0]  r_q, base_q;
    logic [IW-1:0] bit_q;
    logic [1:0]    lead_q;
`endif

    assign accept = start & ready;

    // decode the requested op into its first compute state
    always_comb begin
        bad_op   = 1'b0;
        go_state = S_ARITH;
        case (op)
            OP_ADD, OP_SUB: go_state = S_ARITH;
            OP_RED:         go_state = S_RED;
            OP_MUL:         go_state = S_MUL;
`ifdef MODARITH_EXP_EN
            OP_EXP:         go_state = S_EXP_MUL;
`endif
            default:        bad_op = 1'b1;
        endcase
        if (modulant == '0) begin
            bad_op   = 1'b1;
            go_state = S_ARITH;
        end
    end

    // single-cycle add/sub and the final restoring step of reduce
    always_comb begin
        mx      = {1'b0, m_q};
        sum_ab  = {1'b0, a_q} + {1'b0, b_q};
        add_r   = W'((sum_ab >= mx) ? sum_ab - mx : sum_ab);
        sub_r   = W'((a_q >= b_q) ? {1'b0, a_q} - {1'b0, b_q}
                                  : {1'b0, a_q} - {1'b0, b_q} + mx);
        red_r   = W'((rem_q >= mx) ? rem_q - mx : rem_q);
        arith_r = err_q ? '0 : ((op_q == OP_SUB) ? sub_r : add_r);
    end

    // multiplier launch and operand steering
    always_comb begin
        mul_start = 1'b0;
        mul_x     = a;
        mul_y     = b;
        mul_m     = modulant;
        if (accept && go_state == S_MUL) begin
            mul_start = 1'b1;
`ifdef MODARITH_EXP_EN
        end else if (state_q == S_EXP_MUL && lead_q == 2'd1 && !mul_busy) begin
            mul_start = 1'b1;
            mul_x     = r_q;
            mul_y     = base_q;
            mul_m     = m_q;
        end else if (state_q == S_EXP_MUL && mul_done) begin
            mul_start = 1'b1;
            mul_x     = base_q;
            mul_y     = base_q;
            mul_m     = m_q;
        end else if (state_q == S_EXP_SQ && mul_done && bit_q != IW'(W - 1)) begin
            mul_start = 1'b1;
            mul_x     = r_q;
            mul_y     = mul_p;
            mul_m     = m_q;
`endif
        end
    end

    modmul_serial #(
        .DATA_WIDTH(W)
    ) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .x     (mul_x),
        .y     (mul_y),
        .m     (mul_m),
        .busy  (mul_busy),
        .done  (mul_done),
        .p     (mul_p)
    );

    // control FSM with registered handshake and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            err_q   <= 1'b0;
            div_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            ready   <= 1'b1;
            done    <= 1'b0;
            result  <= '0;
            error   <= 1'b0;
`ifdef MODARITH_EXP_EN
            r_q     <= '0;
            base_q  <= '0;
            bit_q   <= '0;
            lead_q  <= '0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state_q)
                S_IDLE, S_FIN: begin
                    if (accept) begin
                        state_q <= go_state;
                        op_q    <= op;
                        a_q     <= a;
                        b_q     <= b;
                        m_q     <= modulant;
                        err_q   <= bad_op;
                        div_q   <= {a, b};
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        ready   <= 1'b0;
`ifdef MODARITH_EXP_EN
                        r_q     <= W'(modulant != W'(1));
                        base_q  <= a;
                        bit_q   <= '0;
                        lead_q  <= 2'd2;
`endif
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ARITH: begin
                    state_q <= S_FIN;
                    ready   <= 1'b1;
                    done    <= 1'b1;
                    result  <= arith_r;
                    error   <= err_q;
                end
                S_RED: begin
                    if (cnt_q == CW'(RED_LAST)) begin
                        state_q <= S_FIN;
                        ready   <= 1'b1;
                        done    <= 1'b1;
                        result  <= red_r;
                        error   <= 1'b0;
                    end else begin
                        rem_q <= {red_r, div_q[2*W-1]};
                        div_q <= {div_q[2*W-2:0], 1'b0};
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_MUL: begin
                    if (mul_done && !mul_busy) begin
                        state_q <= S_FIN;
                        ready   <= 1'b1;
                        done    <= 1'b1;
                        result  <= mul_p;
                        error   <= 1'b0;
                    end
                end
`ifdef MODARITH_EXP_EN
                S_EXP_MUL: begin
                    if (lead_q != 2'd0) lead_q <= lead_q - 2'd1;
                    if (mul_done) begin
                        if (b_q[bit_q]) r_q <= mul_p;
                        state_q <= S_EXP_SQ;
                    end
                end
                S_EXP_SQ: begin
                    if (mul_done) begin
                        base_q <= mul_p;
                        if (bit_q == IW'(W - 1)) begin
                            state_q <= S_FIN;
                            ready   <= 1'b1;
                            done    <= 1'b1;
                            result  <= r_q;
                            error   <= 1'b0;
                        end else begin
                            bit_q   <= bit_q + IW'(1);
                            state_q <= S_EXP_MUL;
                        end
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_modarith_engine.sv
// tb_modarith_engine: directed and random checks of modarith_engine
// against a plain-arithmetic reference model.
module tb_modarith_engine;
    localparam int W = 8;
`ifdef MODARITH_EXP_EN
    localparam bit EXP_EN = 1'b1;
`else
    localparam bit EXP_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] modulant = '0;
    logic         ready, done, error;
    logic [W-1:0] result;

    int checks = 0;
    int errors = 0;

    modarith_engine #(.DATA_WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .modulant (modulant),
        .ready    (ready),
        .done     (done),
        .result   (result),
        .error    (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    function automatic void model(input logic [2:0] o, input int x, y, mm,
                                  output int r, output int e, output int l);
        e = 0;
        r = 0;
        l = 1;
        if (mm == 0 || o > 3'd4 || (o == 3'd4 && !EXP_EN)) begin
            e = 1;
            return;
        end
        case (o)
            3'd0: r = (x + y) % mm;
            3'd1: r = (x + mm - y) % mm;
            3'd2: begin r = (x * 256 + y) % mm; l = 2 * W + 1; end
            3'd3: begin r = (x * y) % mm; l = W + 1; end
            default: begin
                r = 1 % mm;
                for (int k = 0; k < y; k++) r = (r * x) % mm;
                l = 2 * W * (W + 1) + 2;
            end
        endcase
    endfunction

    // Issues one op and returns at #1 after its done edge (the done cycle).
    task automatic run(input string tag, input logic [2:0] o,
                       input int x, y, mm, input int poke);
        int er, ee, el, lat;
        model(o, x, y, mm, er, ee, el);
        op = o;
        a = W'(x);
        b = W'(y);
        modulant = W'(mm);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        modulant = W'($urandom);
        op = 3'($urandom);
        chk({tag, " ready_low"}, 32'(ready), 0);
        lat = 0;
        while (done !== 1'b1 && lat < 400) begin
            if (lat == poke) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
        end
        chk({tag, " latency"}, lat, el);
        chk({tag, " result"}, 32'(result), er);
        chk({tag, " error"}, 32'(error), ee);
        chk({tag, " ready"}, 32'(ready), 1);
    endtask

    initial begin
        int dcount;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst ready", 32'(ready), 1);
        chk("rst done", 32'(done), 0);
        chk("rst result", 32'(result), 0);
        chk("rst error", 32'(error), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run("add", 3'b000, 200, 100, 251, -1);
        run("sub b2b", 3'b001, 5, 10, 13, -1);
        repeat (2) @(posedge clk);
        #1;

        run("mul", 3'b011, 6, 7, 10, 3);
        @(posedge clk);
        #1;
        chk("mul done pulse", 32'(done), 0);

        run("red", 3'b010, 8'h12, 8'h34, 97, -1);
        run("red m0", 3'b010, 8'h12, 8'h34, 0, -1);
        run("exp", 3'b100, 3, 5, 7, -1);
        run("exp b0", 3'b100, 3, 0, 7, -1);
        run("exp m1", 3'b100, 0, 3, 1, -1);
        run("op111", 3'b111, 1, 2, 5, -1);
        run("op101", 3'b101, 1, 2, 5, -1);

        for (int i = 0; i < 24; i++) begin
            int mm, x, y;
            logic [2:0] o;
            o  = 3'($urandom_range(0, 5));
            if (o == 3'd5) o = 3'($urandom_range(5, 7));
            mm = $urandom_range(1, 255);
            x  = $urandom_range(0, mm - 1);
            y  = $urandom_range(0, mm - 1);
            run($sformatf("rnd%0d op%0d", i, o), o, x, y, mm, -1);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
            end
        end

        run("mul pre-abort", 3'b011, 6, 7, 10, -1);
        op = EXP_EN ? 3'b100 : 3'b010;
        a = 8'd3;
        b = 8'd5;
        modulant = 8'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (EXP_EN ? 49 : 8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort ready", 32'(ready), 1);
        chk("abort done", 32'(done), 0);
        chk("abort result", 32'(result), 0);
        chk("abort error", 32'(error), 0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        repeat (200) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dcount++;
        end
        chk("abort no done", dcount, 0);
        run("add post", 3'b000, 1, 1, 3, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
